// File: rtl/slot_capture.sv
// slot_capture: recovers a 16-slot serial frame from a 1-bit line.
// Each frame runs SLOT_LEN*16 clocks. The line is sampled once per slot, at phase SAMPLE_OFS.
// Every sample produces a write strobe for a 16-entry store.
// The assembled frame is presented with a one-cycle valid pulse.
// Valid settings: SLOT_LEN*16 <= 256 and SAMPLE_OFS < SLOT_LEN.
module slot_capture #(
    parameter int unsigned SLOT_LEN   = 13,
    parameter int unsigned SAMPLE_OFS = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        din_i,
    output logic [7:0]  count_o,
    output logic [3:0]  addr_o,
    output logic        wr_en_o,
    output logic        wr_data_o,
    output logic [15:0] frame_o,
    output logic        frame_valid_o,
    output logic        busy_o,
    output logic        overrun_o
);

    // The phase counter must hold SLOT_LEN-1. It stays at least one bit wide for SLOT_LEN == 1.
    localparam int unsigned PhaseW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(SLOT_LEN - 1);
    localparam logic [PhaseW-1:0] SampleOfs = PhaseW'(SAMPLE_OFS);
    localparam logic [7:0]        LastCount = 8'(SLOT_LEN * 16 - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [3:0]        slot_q, slot_d;
    logic [3:0]        addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_data_q, wr_data_d;
    logic [15:0]       frame_q, frame_d;
    logic              frame_valid_q, frame_valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    // Next-state logic: frame sequencing, mid-slot sampling and the single-cycle pulses.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        phase_d       = phase_q;
        slot_d        = slot_q;
        addr_d        = addr_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        busy_d        = busy_q;
        overrun_d     = 1'b0;

        case (state_q)
            StIdle: begin
                count_d = 8'd0;
                busy_d  = 1'b0;
                if (start_i) begin
                    state_d = StRun;
                    phase_d = '0;
                    slot_d  = 4'd0;
                    busy_d  = 1'b1;
                end
            end

            StRun: begin
                // A start request mid-frame is reported but never disturbs the capture.
                overrun_d = start_i;

                // Sampling is independent of the end-of-frame check.
                // This keeps the final slot sampled when SAMPLE_OFS == SLOT_LEN-1.
                if (phase_q == SampleOfs) begin
                    frame_d[slot_q] = din_i;
                    wr_data_d       = din_i;
                    addr_d          = slot_q;
                    wr_en_d         = 1'b1;
                end

                if (count_q == LastCount) begin
                    state_d       = StDone;
                    count_d       = 8'd0;
                    phase_d       = '0;
                    slot_d        = 4'd0;
                    busy_d        = 1'b0;
                    frame_valid_d = 1'b1;
                end else begin
                    count_d = count_q + 8'd1;
                    if (phase_q == PhaseLast) begin
                        phase_d = '0;
                        slot_d  = slot_q + 4'd1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end

            StDone: begin
                count_d = 8'd0;
                phase_d = '0;
                slot_d  = 4'd0;
                if (start_i) begin
                    // Back-to-back frame: count restarts at 0 on the very next cycle.
                    state_d = StRun;
                    busy_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                count_d = 8'd0;
                phase_d = '0;
                slot_d  = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset has priority and clears the captured frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            count_q       <= 8'd0;
            phase_q       <= '0;
            slot_q        <= 4'd0;
            addr_q        <= 4'd0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= 1'b0;
            frame_q       <= 16'h0000;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            phase_q       <= phase_d;
            slot_q        <= slot_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign count_o       = count_q;
    assign addr_o        = addr_q;
    assign wr_en_o       = wr_en_q;
    assign wr_data_o     = wr_data_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = frame_valid_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_slot_capture.sv
// Directed bench for slot_capture at default parameters (13 clocks per slot, sample at phase 6).
module tb_slot_capture;

    logic        clk;
    logic        rst;
    logic        start;
    logic        din;
    logic [7:0]  count;
    logic [3:0]  addr;
    logic        wr_en;
    logic        wr_data;
    logic [15:0] frame;
    logic        frame_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    slot_capture #(
        .SLOT_LEN  (13),
        .SAMPLE_OFS(6)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .din_i        (din),
        .count_o      (count),
        .addr_o       (addr),
        .wr_en_o      (wr_en),
        .wr_data_o    (wr_data),
        .frame_o      (frame),
        .frame_valid_o(frame_valid),
        .busy_o       (busy),
        .overrun_o    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next cycle. Outputs are read 1ns after the edge, and inputs driven here
    // are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".addr"}, 32'(addr), 32'd0);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, ".wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, ".frame"}, 32'(frame), 32'd0);
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".overrun"}, 32'(overrun), 32'd0);
    endtask

    // The caller drives start=1 in the current cycle. This task then steps through the 208
    // RUN cycles, checking each one. For slot n it drives data[n], inverted at every phase
    // other than 6 when glitch is set. It pulses start at counts ov1/ov2.
    // If abort_at >= 0, rst is raised at that count. Otherwise the DONE cycle is checked,
    // and start is left at chain.
    task automatic run_frame(input logic [15:0] data, input bit glitch, input int ov1,
                             input int ov2, input int abort_at, input bit chain);
        bit prev_start;
        int slot;
        int ws;
        prev_start = 1'b0;
        for (int c = 0; c < 208; c++) begin
            step();
            slot = c / 13;
            chk($sformatf("count@%0d", c), 32'(count), 32'(c));
            chk($sformatf("busy@%0d", c), 32'(busy), 32'd1);
            chk($sformatf("frame_valid@%0d", c), 32'(frame_valid), 32'd0);
            chk($sformatf("overrun@%0d", c), 32'(overrun), 32'(prev_start));
            if (c >= 7 && (c % 13) == 7) begin
                ws = (c - 7) / 13;
                chk($sformatf("wr_en@%0d", c), 32'(wr_en), 32'd1);
                chk($sformatf("addr@%0d", c), 32'(addr), 32'(ws));
                chk($sformatf("wr_data@%0d", c), 32'(wr_data), 32'(data[ws]));
            end else begin
                chk($sformatf("wr_en@%0d", c), 32'(wr_en), 32'd0);
            end
            if (c == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                step();
                rst = 1'b0;
                chk_reset_vals("abort");
                return;
            end
            start      = (c == ov1) || (c == ov2);
            prev_start = start;
            din        = data[slot] ^ (glitch && ((c % 13) != 6));
        end
        step();
        chk("done.frame_valid", 32'(frame_valid), 32'd1);
        chk("done.frame", 32'(frame), 32'(data));
        chk("done.count", 32'(count), 32'd0);
        chk("done.busy", 32'(busy), 32'd0);
        chk("done.wr_en", 32'(wr_en), 32'd0);
        chk("done.overrun", 32'(overrun), 32'd0);
        start = chain;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Idle with a toggling line: nothing may move.
        for (int i = 0; i < 20; i++) begin
            din = i[0];
            step();
            chk($sformatf("idle.count@%0d", i), 32'(count), 32'd0);
            chk($sformatf("idle.wr_en@%0d", i), 32'(wr_en), 32'd0);
            chk($sformatf("idle.frame@%0d", i), 32'(frame), 32'd0);
            chk($sformatf("idle.busy@%0d", i), 32'(busy), 32'd0);
            chk($sformatf("idle.frame_valid@%0d", i), 32'(frame_valid), 32'd0);
        end

        // Plain frame.
        start = 1'b1;
        run_frame(16'hA5C3, 1'b0, -1, -1, -1, 1'b0);

        // The frame stays stable in IDLE.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold.frame", 32'(frame), 32'h0000A5C3);
            chk("hold.frame_valid", 32'(frame_valid), 32'd0);
            chk("hold.busy", 32'(busy), 32'd0);
            chk("hold.count", 32'(count), 32'd0);
        end

        // The line is inverted everywhere except the sample phase.
        start = 1'b1;
        run_frame(16'hA5C3, 1'b1, -1, -1, -1, 1'b0);
        step();

        // Start pulses mid-frame at counts 50 and 100, then a chained frame via start in DONE.
        start = 1'b1;
        run_frame(16'hA5C3, 1'b0, 50, 100, -1, 1'b1);
        run_frame(16'h3C5A, 1'b0, -1, -1, -1, 1'b0);
        step();
        chk("post_chain.busy", 32'(busy), 32'd0);
        chk("post_chain.frame", 32'(frame), 32'h00003C5A);

        // Reset at count 120 aborts the frame.
        start = 1'b1;
        run_frame(16'hFFFF, 1'b0, -1, -1, 120, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("after_abort.frame_valid", 32'(frame_valid), 32'd0);
            chk("after_abort.frame", 32'(frame), 32'd0);
            chk("after_abort.busy", 32'(busy), 32'd0);
        end

        // A fresh frame after the abort captures correctly.
        start = 1'b1;
        run_frame(16'h6E19, 1'b0, -1, -1, -1, 1'b0);
        step();
        chk("final.frame", 32'(frame), 32'h00006E19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
